// File: rtl/multiword_add_pkg.sv
// Shared types and width helpers for the sequential multi-word adder controller.
package multiword_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int total_w(input int word_w, input int n_words);
    return word_w * n_words;
  endfunction

  // Word index is at least one bit so N_WORDS=1 still has a legal counter.
  function automatic int idx_w(input int n_words);
    return (n_words > 1) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer driving an external WORD_W-bit adder one word per cycle, LSW first.
// Optional MULTIWORD_ADD_SUB_EN adds in_sub: subtract via inverted B words and carry-in forced to 1.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter  int WORD_W  = 4,
  parameter  int N_WORDS = 4,
  localparam int TOTAL_W = total_w(WORD_W, N_WORDS),
  localparam int IDX_W   = idx_w(N_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] in_a,
  input  logic [TOTAL_W-1:0] in_b,
  input  logic               in_ci,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic               in_sub,
`endif
  output logic [WORD_W-1:0]  add_a,
  output logic [WORD_W-1:0]  add_b,
  output logic               add_ci,
  input  logic [WORD_W-1:0]  add_s,
  input  logic               add_co,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_s,
  output logic               out_co
);

  typedef logic [N_WORDS-1:0][WORD_W-1:0] words_t;

  state_t             state, state_nx;
  words_t             a_reg, b_reg, res;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;
  logic               accept, last;
  logic [WORD_W-1:0]  b_word;
`ifdef MULTIWORD_ADD_SUB_EN
  logic               sub_reg;
`endif

  assign accept = in_valid & in_ready;
  assign last   = (idx == IDX_W'(N_WORDS - 1));
  assign out_s  = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)                 state_nx = RUN;
      RUN:     if (last)                   state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  // Adder operands come only from registers, never from upstream inputs.
  always_comb begin
    b_word = b_reg[idx];
`ifdef MULTIWORD_ADD_SUB_EN
    if (sub_reg) b_word = ~b_reg[idx];
`endif
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_reg[idx];
      add_b  = b_word;
      add_ci = carry_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_co    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      in_ready <= (state_nx == IDLE);
      unique case (state)
        IDLE: if (accept) begin
          a_reg     <= in_a;
          b_reg     <= in_b;
          idx       <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
          sub_reg   <= in_sub;
          carry_reg <= in_sub ? 1'b1 : in_ci;
`else
          carry_reg <= in_ci;
`endif
        end
        RUN: begin
          res[idx]  <= add_s;
          carry_reg <= add_co;
          if (last) begin
            out_co    <= add_co;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench: arithmetic model of the wide add checked every cycle, plus literal expectations.
module tb_multiword_add_seq;

  localparam int WORD_W  = 4;
  localparam int N_WORDS = 4;
  localparam int TW      = WORD_W * N_WORDS;
  localparam logic [63:0] TMASK = (64'd1 << TW) - 1;
  localparam logic [63:0] WMASK = (64'd1 << WORD_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [TW-1:0] in_a = '0, in_b = '0;
  logic          in_ci = 1'b0, in_sub = 1'b0;
  logic [WORD_W-1:0] add_a, add_b, add_s;
  logic          add_ci, add_co;
  logic          out_valid, out_ready = 1'b1, out_co;
  logic [TW-1:0] out_s;

  multiword_add_seq #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
`ifdef MULTIWORD_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_co(out_co)
  );

  // External combinational adder
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_ci};

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Model state, advanced by the compare process at each falling edge
  typedef enum int {P_RST, P_IDLE, P_RUN, P_DONE, P_HS} ph_t;
  ph_t ph = P_RST;
  int  k = 0, done_cnt = 0;
  logic [63:0] m_a, m_be, m_ci;
  logic [TW-1:0] last_s;
  logic last_co;
  logic [N_WORDS-1:0] ci_seq;

  always @(negedge clk) begin
    logic [63:0] sum, mk, cin;
    sum = m_a + m_be + m_ci;
    if (!rst_n) begin
      chk("rst out_valid", out_valid, 0);
      chk("rst in_ready", in_ready, 0);
      chk("rst out_s", out_s, 0);
      chk("rst out_co", out_co, 0);
      chk("rst add bus", {add_a, add_b, add_ci}, 0);
      ph = P_RST;
    end else begin
      case (ph)
        P_RST: begin
          chk("post-rst in_ready", in_ready, 0);
          ph = P_IDLE;
        end
        P_IDLE: begin
          chk("idle out_valid", out_valid, 0);
          chk("idle in_ready", in_ready, 1);
          chk("idle add bus", {add_a, add_b, add_ci}, 0);
        end
        P_RUN: begin
          mk  = (64'd1 << (WORD_W * k)) - 1;
          cin = ((m_a & mk) + (m_be & mk) + m_ci) >> (WORD_W * k);
          chk($sformatf("run%0d add_a", k), add_a, (m_a >> (WORD_W * k)) & WMASK);
          chk($sformatf("run%0d add_b", k), add_b, (m_be >> (WORD_W * k)) & WMASK);
          chk($sformatf("run%0d add_ci", k), add_ci, cin);
          chk("run out_valid", out_valid, 0);
          chk("run in_ready", in_ready, 0);
          ci_seq[k] = add_ci;
          k++;
          if (k == N_WORDS) ph = P_DONE;
        end
        P_DONE: begin
          chk("done out_valid", out_valid, 1);
          chk("done out_s", out_s, sum & TMASK);
          chk("done out_co", out_co, sum >> TW);
          chk("done in_ready", in_ready, 0);
          chk("done add bus", {add_a, add_b, add_ci}, 0);
          last_s = out_s;
          last_co = out_co;
          done_cnt++;
          if (out_ready) ph = P_HS;
        end
        P_HS: begin
          chk("hs out_valid", out_valid, 0);
          chk("hs in_ready", in_ready, 1);
          ph = P_IDLE;
        end
        default: ;
      endcase
      if ((ph == P_IDLE) && in_valid && in_ready) begin
        m_a  = 64'(in_a);
        m_be = in_sub ? (~64'(in_b)) & TMASK : 64'(in_b);
        m_ci = in_sub ? 64'd1 : 64'(in_ci);
`ifndef MULTIWORD_ADD_SUB_EN
        m_be = 64'(in_b);
        m_ci = 64'(in_ci);
`endif
        k = 0;
        done_cnt = 0;
        ph = P_RUN;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (ph != P_IDLE && n < 100) begin @(posedge clk); #1; n++; end
    if (ph != P_IDLE) timeout(nm);
  endtask

  task automatic start_op(input logic [TW-1:0] a, b, input logic ci, sub, noise);
    int n = 0;
    in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
    while (ph == P_IDLE && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    if (ph == P_IDLE) timeout("accept");
    else if (noise) begin
      // Operands offered mid-RUN must be ignored
      in_a = 16'hAAAA; in_b = 16'h5555; in_ci = 1'b1; in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [TW-1:0] a, b, input logic ci, sub, noise, input int hold);
    int n = 0;
    start_op(a, b, ci, sub, noise);
    if (hold > 0) begin
      while (ph != P_DONE && n < 20) begin @(posedge clk); #1; n++; end
      if (ph != P_DONE) timeout("reach done");
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    wait_idle("op complete");
  endtask

  initial begin
    int n;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    wait_idle("reset release");

    // 1: no carries
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 0);
    chk("t1 out_s", last_s, 16'h2345);
    chk("t1 out_co", last_co, 0);
    chk("t1 ci seq", ci_seq, 4'b0000);
    chk("t1 done cycles", done_cnt, 1);

    // 2: carry ripples through every word, with ignored mid-RUN offer
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 0);
    chk("t2 out_s", last_s, 16'h0000);
    chk("t2 out_co", last_co, 1);
    chk("t2 ci seq", ci_seq, 4'b1110);

    // 3: carry-in only
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    chk("t3 out_s", last_s, 16'h0000);
    chk("t3 out_co", last_co, 1);
    chk("t3 ci seq", ci_seq, 4'b1111);

    // 4: downstream stall for 10 cycles
    out_ready = 1'b0;
    run_op(16'hBEEF, 16'h1234, 1'b1, 1'b0, 1'b0, 10);
    chk("t4 out_s", last_s, 16'hD124);
    chk("t4 out_co", last_co, 0);
    chk("t4 done cycles", done_cnt, 11);

    // 5: reset at idx=2 discards the op
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(ph == P_RUN && k == 2) && n < 20) begin @(posedge clk); #1; n++; end
    if (!(ph == P_RUN && k == 2)) timeout("reach idx2");
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    wait_idle("reset recovery");
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 0);
    chk("t5 out_s", last_s, 16'h0007);
    chk("t5 out_co", last_co, 0);

`ifdef MULTIWORD_ADD_SUB_EN
    // 6: subtraction, in_ci ignored
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0);
    chk("t6a out_s", last_s, 16'hFFFE);
    chk("t6a out_co", last_co, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 0);
    chk("t6b out_s", last_s, 16'h0002);
    chk("t6b out_co", last_co, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
